pdm_deserializer_hs: RTL and testbench
======================================

Name: pdm_deserializer_hs

Overview:
- Parametrised successor to the first-generation PDM microphone deserializer.
- Generates the PDM microphone clock internally from the 100 MHz system clock instead of passing the system clock through.
- Shifts the mic bitstream into WORD_W-bit words and hands them to the memory writer over a valid/ready handshake.
- Flags words dropped because the consumer is not ready (overrun). Sits between the PDM mic pins and the sample-buffer writer.

Parameters:
- WORD_W, 16, bits per output word; legal 2..32.
- CLK_DIV, 100, system clocks per PDM clock period; even, >= 4 (100 gives 1 MHz at 100 MHz).

Ports:
- clock  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- enable  in  1  capture enable; level-sensitive
- chan_sel  in  1  mic channel select; latched on IDLE->RUN
- data_in  in  1  PDM bitstream from mic
- pdm_clk_o  out  1  generated mic clock, registered
- pdm_irsel_o  out  1  mic L/R select, registered
- data  out  WORD_W  completed word, MSB = oldest bit
- data_valid  out  1  data holds an unconsumed word
- data_ready  in  1  consumer accepts data this cycle
- clear_overrun  in  1  clears the sticky overrun flag
- overrun  out  1  sticky: a completed word was dropped

Behaviour:
- Reset (sync, active-high, overrides everything):
  - State = IDLE; div_cnt = 0; bit_cnt = 0; shift register = 0.
  - pdm_clk_o = 0, pdm_irsel_o = 0, data = 0, data_valid = 0, overrun = 0.
- State machine: IDLE, RUN.
  - IDLE: div_cnt and bit_cnt held at 0; shift register cleared; pdm_clk_o = 0.
  - IDLE -> RUN: at the edge where enable = 1. pdm_irsel_o <= chan_sel on the same edge.
  - RUN -> IDLE: at the edge where enable = 0. The partial word is discarded; the pending output word and data_valid are retained until handshaked.
- Clock divider (RUN only):
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pdm_clk_o <= 1 when the next div_cnt >= CLK_DIV/2, else 0. Low half period first, then high; 50% duty.
- Sample tick: the edge at which div_cnt == CLK_DIV/2-1 (last system cycle before the pdm_clk_o rising edge).
- Shifting on each tick:
  - shift <= {shift[WORD_W-2:0], data_in}.
  - bit_cnt increments, wrapping at WORD_W-1 -> 0.
- Word completion (tick with bit_cnt == WORD_W-1), using the word including the current data_in:
  - If data_valid == 0, or data_valid && data_ready this edge: data <= word, data_valid <= 1.
  - Otherwise: word dropped, data unchanged, overrun <= 1.
- Handshake:
  - Transfer occurs at the edge where data_valid && data_ready.
  - data is stable while data_valid = 1.
  - data_valid falls after a transfer unless a new word loads on the same edge, in which case it stays 1 with the new data.
- overrun: set wins over clear_overrun on the same edge; otherwise clear_overrun drives it to 0.
- Latency: first data_valid asserts CLK_DIV/2 + (WORD_W-1)*CLK_DIV cycles after the enable-sampling edge. After that, one word every WORD_W*CLK_DIV cycles.
- chan_sel changes during RUN have no effect until the next IDLE->RUN transition.
- enable toggling within one PDM period restarts the divider and bit count from 0.

Optional Feature:
- Macro: PDM_OVF_COUNT_EN.
- Defined:
  - Adds output port overrun_count (8 bits).
  - Increments on every dropped word and saturates at 255.
  - Cleared to 0 by reset or by clear_overrun; increment wins over clear on the same edge, giving 1.
- Undefined: port and counter are absent; only the sticky overrun flag exists.

Test Plan:
- WORD_W=4, CLK_DIV=4, data_ready=1, data_in pattern 1,0,1,1 at successive ticks -> data_valid high 14 cycles after the enable-sampling edge; data = 4'b1011; pdm_clk_o is 0,0,1,1 repeating.
- Defaults, chan_sel=1, enable held -> pdm_clk_o period 100 cycles, 50 high; pdm_irsel_o = 1; one word every 1600 cycles.
- WORD_W=4, CLK_DIV=4, data_ready=0 for 2 word periods -> first word held stable; second word dropped; overrun = 1. Then clear_overrun -> overrun = 0.
- Transfer coincident with word completion (data_ready=1 on that edge) -> data_valid stays 1; data updates to the new word; no overrun.
- enable dropped after 2 of 4 bits, then re-raised -> partial bits discarded; next word contains only bits sampled after re-enable. reset mid-RUN -> all outputs 0 on the next cycle.
- PDM_OVF_COUNT_EN, data_ready=0 for 300 word periods -> overrun_count saturates at 255. clear_overrun coincident with a drop -> overrun_count = 1.

Source files
------------

// File: rtl/pdm_deserializer_hs.sv
// rtl/pdm_deserializer_hs.sv - PDM mic clock generator and WORD_W-bit word deserializer with valid/ready output
// Optional overrun counter port enabled by defining PDM_OVF_COUNT_EN.
module pdm_deserializer_hs #(
    parameter int WORD_W  = 16,
    parameter int CLK_DIV = 100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              chan_sel,
    input  logic              data_in,
    output logic              pdm_clk_o,
    output logic              pdm_irsel_o,
    output logic [WORD_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ready,
    input  logic              clear_overrun,
    output logic              overrun
`ifdef PDM_OVF_COUNT_EN
    ,
    output logic [7:0]        overrun_count
`endif
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_TICK = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q,   state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   shift_q,   shift_d;
    logic                pdm_clk_q, pdm_clk_d;
    logic                irsel_q,   irsel_d;
    logic [WORD_W-1:0]   data_q,    data_d;
    logic                valid_q,   valid_d;
    logic                ovr_q,     ovr_d;

    logic [DIV_W-1:0]    div_nxt;
    logic [WORD_W-1:0]   word;
    logic                xfer;
    logic                word_done;
    logic                drop;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            pdm_clk_q <= 1'b0;
            irsel_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            pdm_clk_q <= pdm_clk_d;
            irsel_q   <= irsel_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pdm_clk_d = pdm_clk_q;
        irsel_d   = irsel_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        div_nxt   = '0;
        word      = {shift_q[WORD_W-2:0], data_in};
        word_done = 1'b0;
        xfer      = valid_q & data_ready;

        if (xfer) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                shift_d   = '0;
                pdm_clk_d = 1'b0;
                if (enable) begin
                    state_d = ST_RUN;
                    irsel_d = chan_sel;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // Leaving RUN drops the partial word; a pending output word survives.
                    state_d   = ST_IDLE;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    pdm_clk_d = 1'b0;
                end else begin
                    div_nxt   = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
                    div_cnt_d = div_nxt;
                    pdm_clk_d = (div_nxt >= DIV_HALF);
                    if (div_cnt_q == DIV_TICK) begin
                        shift_d = word;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            word_done = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        drop = word_done & valid_q & ~data_ready;
        if (word_done && !drop) begin
            data_d  = word;
            valid_d = 1'b1;
        end

        if (drop) begin
            ovr_d = 1'b1;
        end else if (clear_overrun) begin
            ovr_d = 1'b0;
        end
    end

`ifdef PDM_OVF_COUNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;
    logic [7:0] ovf_base;

    // Clear is applied first so a drop on the clearing edge leaves a count of 1.
    always_comb begin
        ovf_base  = clear_overrun ? 8'd0 : ovf_cnt_q;
        ovf_cnt_d = ovf_base;
        if (drop) begin
            ovf_cnt_d = (ovf_base == 8'hFF) ? 8'hFF : ovf_base + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign overrun_count = ovf_cnt_q;
`endif

    assign pdm_clk_o   = pdm_clk_q;
    assign pdm_irsel_o = irsel_q;
    assign data        = data_q;
    assign data_valid  = valid_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_pdm_deserializer_hs.sv
// tb/tb_pdm_deserializer_hs.sv - self-checking bench for pdm_deserializer_hs (optional PDM_OVF_COUNT_EN)
module tb_pdm_deserializer_hs;

    localparam int WORD_W  = 4;
    localparam int CLK_DIV = 4;
    localparam int HALF    = CLK_DIV / 2;

    logic clock         = 1'b0;
    logic reset         = 1'b1;
    logic enable        = 1'b0;
    logic chan_sel      = 1'b0;
    logic data_in       = 1'b0;
    logic data_ready    = 1'b0;
    logic clear_overrun = 1'b0;
    logic              pdm_clk_o;
    logic              pdm_irsel_o;
    logic [WORD_W-1:0] data;
    logic              data_valid;
    logic              overrun;
    logic [7:0]        cnt_dut;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    pdm_deserializer_hs #(.WORD_W(WORD_W), .CLK_DIV(CLK_DIV)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .chan_sel      (chan_sel),
        .data_in       (data_in),
        .pdm_clk_o     (pdm_clk_o),
        .pdm_irsel_o   (pdm_irsel_o),
        .data          (data),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .clear_overrun (clear_overrun),
        .overrun       (overrun)
`ifdef PDM_OVF_COUNT_EN
        ,
        .overrun_count (cnt_dut)
`endif
    );

`ifndef PDM_OVF_COUNT_EN
    assign cnt_dut = 8'd0;
`endif

    // Reference model: counts RUN cycles since capture start and collects sampled bits in a queue.
    bit                m_live = 1'b0;
    bit                m_run;
    int                m_n;
    bit                m_bits[$];
    bit                m_clk, m_irsel, m_valid, m_ovr;
    logic [WORD_W-1:0] m_data;
    int                m_cnt;
    int                m_w;
    bit                m_done, m_drop, m_xfer;

    always @(posedge clock) begin
        if (reset) begin
            m_live = 1'b1; m_run = 1'b0; m_n = 0; m_bits.delete();
            m_clk = 1'b0; m_irsel = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
            m_data = '0; m_cnt = 0;
        end else if (m_live) begin
            m_xfer = m_valid && data_ready;
            m_done = 1'b0;
            m_w    = 0;
            if (!m_run) begin
                m_n = 0; m_bits.delete(); m_clk = 1'b0;
                if (enable) begin
                    m_run   = 1'b1;
                    m_irsel = chan_sel;
                end
            end else if (!enable) begin
                m_run = 1'b0; m_n = 0; m_bits.delete(); m_clk = 1'b0;
            end else begin
                if (m_n % CLK_DIV == HALF - 1) begin
                    m_bits.push_back(data_in);
                    if (m_bits.size() == WORD_W) begin
                        foreach (m_bits[i]) m_w = m_w * 2 + int'(m_bits[i]);
                        m_done = 1'b1;
                        m_bits.delete();
                    end
                end
                m_n++;
                m_clk = (m_n % CLK_DIV) >= HALF;
            end
            m_drop = m_done && m_valid && !data_ready;
            if (m_xfer) m_valid = 1'b0;
            if (m_done && !m_drop) begin
                m_data  = WORD_W'(m_w);
                m_valid = 1'b1;
            end
            if (m_drop) m_ovr = 1'b1;
            else if (clear_overrun) m_ovr = 1'b0;
            if (m_drop) m_cnt = ((clear_overrun ? 0 : m_cnt) + 1 > 255) ? 255 : (clear_overrun ? 0 : m_cnt) + 1;
            else if (clear_overrun) m_cnt = 0;
        end
    end

    function automatic bit model_will_drop();
        return m_run && enable && (m_n % CLK_DIV == HALF - 1) &&
               (m_bits.size() == WORD_W - 1) && m_valid && !data_ready;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] m_cnt8;
    always @(negedge clock) begin
        if (m_live && !reset) begin
`ifdef PDM_OVF_COUNT_EN
            m_cnt8 = 8'(m_cnt);
`else
            m_cnt8 = 8'd0;
`endif
            check("cycle", {pdm_clk_o, pdm_irsel_o, data_valid, overrun, data, cnt_dut},
                  {m_clk, m_irsel, m_valid, m_ovr, m_data, m_cnt8});
        end
    end

    task automatic cyc(input logic en, input logic din, input logic rdy, input logic clr);
        @(negedge clock);
        enable = en; data_in = din; data_ready = rdy; clear_overrun = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic feed(input logic [3:0] pat, input logic rdy);
        for (int k = 0; k < 15; k++) begin
            cyc(1'b1, (k >= 2) ? pat[3 - (k - 2) / 4] : 1'b0, rdy, 1'b0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    logic [3:0] pat;
    bit         found;
    int         rdy_mode;

    initial begin
        do_reset();
        check("reset_outs", {pdm_clk_o, pdm_irsel_o, data_valid, overrun, data}, '0);

        // First word latency, clock shape and channel latch
        chan_sel = 1'b1;
        pat = 4'b1011;
        for (int k = 0; k < 15; k++) begin
            cyc(1'b1, (k >= 2) ? pat[3 - (k - 2) / 4] : 1'b0, 1'b1, 1'b0);
            chan_sel = 1'b0;
            if (k < 4)   check("pdm_clk_shape", pdm_clk_o, (k >= 2));
            if (k == 13) check("valid_before_14", data_valid, 1'b0);
        end
        check("valid_at_14", data_valid, 1'b1);
        check("first_word", data, 4'b1011);
        check("irsel_latched", pdm_irsel_o, 1'b1);

        // Consumer stalls: second word dropped, first held
        for (int k = 15; k < 31; k++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
        check("held_word", data, 4'b1011);
        check("overrun_set", overrun, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("overrun_cleared", overrun, 1'b0);

        // Transfer on the completion edge keeps valid high with the new word
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clock);
            enable = 1'b1; data_in = 1'b1; clear_overrun = 1'b0; data_ready = 1'b0;
            if (m_run && (m_n % CLK_DIV == HALF - 1) && m_bits.size() == WORD_W - 1) begin
                data_ready = 1'b1;
                found = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        check("coincide_found", found, 1'b1);
        check("coincide_valid", data_valid, 1'b1);
        check("coincide_data", data, 4'b1111);
        check("coincide_no_ovr", overrun, 1'b0);

        // Drop and clear on the same edge: set wins
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clock);
            enable = 1'b1; data_ready = 1'b0; data_in = 1'($urandom);
            clear_overrun = model_will_drop();
            found = clear_overrun;
            @(posedge clock);
            #1;
        end
        check("drop_found", found, 1'b1);
        check("ovr_set_wins", overrun, 1'b1);
`ifdef PDM_OVF_COUNT_EN
        check("cnt_clear_drop", cnt_dut, 8'd1);
`endif

        // Enable drop after two bits discards them
        do_reset();
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        feed(4'b0110, 1'b1);
        check("restart_valid", data_valid, 1'b1);
        check("restart_word", data, 4'b0110);

        // Reset mid-RUN
        chan_sel = 1'b1;
        for (int k = 0; k < 7; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("reset_midrun", {pdm_clk_o, pdm_irsel_o, data_valid, overrun, data}, '0);
        reset = 1'b0;

        // Randomized run against the model
        rdy_mode = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) rdy_mode = $urandom_range(0, 2);
            reset = ($urandom_range(0, 499) == 0);
            chan_sel = 1'($urandom);
            cyc(($urandom_range(0, 39) != 0), 1'($urandom),
                (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'($urandom) : 1'b1,
                ($urandom_range(0, 29) == 0));
        end
        reset = 1'b0;

`ifdef PDM_OVF_COUNT_EN
        do_reset();
        for (int i = 0; i < 300 * WORD_W * CLK_DIV + 16; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
        check("cnt_saturated", cnt_dut, 8'd255);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clock);
            enable = 1'b1; data_ready = 1'b0; data_in = 1'($urandom);
            clear_overrun = model_will_drop();
            found = clear_overrun;
            @(posedge clock);
            #1;
        end
        check("sat_drop_found", found, 1'b1);
        check("cnt_after_clear_drop", cnt_dut, 8'd1);
`endif

        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
